warp_scheduler_param: RTL
=========================

Name: warp_scheduler_param

Overview:
Parametrised next-generation warp scheduler. It selects one eligible warp per cycle from NUM_WARPS candidates using a runtime-selectable policy: loose round-robin (LRR) or greedy-then-oldest (GTO) with a bounded greedy run. The result is presented through a registered valid/ready issue handshake to the downstream dispatch stage, which can backpressure.

Parameters:
NUM_WARPS, 32, number of warps tracked (>=2, power of two not required)
WID_W, $clog2(NUM_WARPS), width of warp index
MAX_GREEDY, 4, max consecutive accepted issues of one warp in GTO mode (0 = unlimited)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
warp_ready  input  NUM_WARPS  per-warp ready-to-issue flags
warp_stalled  input  NUM_WARPS  per-warp stall flags (dependency/memory)
policy  input  1  0 = LRR, 1 = GTO
issue_ready  input  1  downstream can accept an issue this cycle
next_warp  output  WID_W  selected warp index (registered)
warp_valid  output  1  next_warp holds a valid selection (registered)

Behaviour:
- eligible[i] = warp_ready[i] & ~warp_stalled[i]; purely combinational from current inputs.
- Accept = warp_valid & issue_ready; one issue per accepting cycle.
- Output slot load condition: ~warp_valid | accept. When loading, the slot registers the selection computed from this cycle's eligible vector. Latency: eligibility at edge N gives warp_valid/next_warp at edge N+1.
- Load with no eligible warp: warp_valid <= 0; next_warp keeps its old value.
- Hold rule: while warp_valid & ~issue_ready, next_warp and warp_valid stay stable, even if that warp becomes ineligible.
- State: last_issued (WID_W) and greedy_cnt (counter, width sufficient for MAX_GREEDY). Both update only on accept, never on selection.
  - On accept: last_issued <= next_warp.
  - greedy_cnt <= greedy_cnt+1 if next_warp == last_issued, else 1; saturates at MAX_GREEDY.
- LRR selection: first eligible warp searching from last_issued+1 upward, wrapping from NUM_WARPS-1 to 0; last_issued itself is checked last.
- Selection with a same-cycle accept: the accepted warp is treated as last_issued, so back-to-back issues rotate without a bubble.
- GTO selection:
  - If last_issued is eligible and (MAX_GREEDY==0 or greedy_cnt < MAX_GREEDY), select last_issued.
  - Otherwise select the lowest-index eligible warp other than last_issued.
  - If last_issued is the only eligible warp, select it; greedy_cnt then continues to saturate and does not block it.
- Policy: sampled at each load; a change takes effect on the next selection. last_issued and greedy_cnt are shared across policies and are not cleared on a switch.
- Reset (asynchronous, takes effect immediately, including mid-handshake): warp_valid=0, next_warp=0, last_issued=NUM_WARPS-1, greedy_cnt=0. The first selection after reset therefore starts at warp 0 in LRR mode and at the lowest eligible warp in GTO mode.
- Index arithmetic: wrap handled explicitly when NUM_WARPS is not a power of two; next_warp never exceeds NUM_WARPS-1.

Test Plan:
1. Reset release, LRR, warp_ready=0x1, issue_ready=1 -> warp_valid=1 one cycle after ready is applied; next_warp=0 every cycle.
2. LRR, warp_ready=0x3, issue_ready=1 -> accepted sequence 0,1,0,1 with no bubbles; warp_ready=0xF and warp_stalled=0x2 -> sequence 0,2,3,0,2.
3. Backpressure: warp_ready=0x3 with issue_ready=0 for 3 cycles while warp_valid=1 -> next_warp frozen at its value (e.g. 1); issue_ready=1 then gives a rotation continuing at 0.
4. GTO, MAX_GREEDY=4, warp_ready=0xC -> sequence 2,2,2,2,3,3,3,3,2; with warp_ready=0x4 only -> 2 issued every cycle indefinitely.
5. All-ineligible: warp_ready=0xF with warp_stalled=0xF after an accept -> warp_valid=0 next cycle; un-stall warp 3 -> warp_valid=1, next_warp=3 one cycle later.
6. Assert reset mid-stream, including while held under backpressure -> warp_valid=0 immediately, before the next edge; after release with warp_ready=0x6 under LRR -> first issue is warp 1.

Source files
------------

// File: rtl/warp_scheduler_param.sv
// Warp scheduler: picks one eligible warp per cycle (loose round-robin or
// greedy-then-oldest) and holds it in a registered valid/ready issue slot.
module warp_scheduler_param #(
  parameter int NUM_WARPS  = 32,
  parameter int WID_W      = $clog2(NUM_WARPS),
  parameter int MAX_GREEDY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] warp_ready,
  input  logic [NUM_WARPS-1:0] warp_stalled,
  input  logic                 policy,
  input  logic                 issue_ready,
  output logic [WID_W-1:0]     next_warp,
  output logic                 warp_valid
);

  // Handshake: the slot content is issued on any cycle where warp_valid and
  // issue_ready are both high; while warp_valid is high and issue_ready is
  // low the slot (warp_valid, next_warp) is held unchanged.

  localparam int CNT_W = (MAX_GREEDY < 1) ? 1 : $clog2(MAX_GREEDY + 1);
  localparam logic [WID_W-1:0] LAST_RST = WID_W'(NUM_WARPS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_GREEDY);
  localparam logic [WID_W:0]   NW_EXT   = (WID_W + 1)'(NUM_WARPS);

  logic [NUM_WARPS-1:0] eligible;
  logic                 accept;
  logic                 load;
  logic                 valid_q, valid_d;
  logic [WID_W-1:0]     next_q, next_d;
  logic [WID_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WID_W-1:0]     lrr_pick;
  logic                 lrr_found;
  logic [WID_W-1:0]     gto_other;
  logic                 other_found;
  logic                 greedy_ok;
  logic                 last_elig;
  logic [WID_W-1:0]     pick;
  logic [WID_W:0]       sum;
  logic [WID_W-1:0]     sel;

  always_comb begin
    eligible    = warp_ready & ~warp_stalled;
    accept      = valid_q & issue_ready;
    load        = ~valid_q | accept;
    last_d      = last_q;
    cnt_d       = cnt_q;
    lrr_pick    = '0;
    lrr_found   = 1'b0;
    gto_other   = '0;
    other_found = 1'b0;
    sum         = '0;
    sel         = '0;
    pick        = '0;
    valid_d     = valid_q;
    next_d      = next_q;

    if (accept) begin
      last_d = next_q;
      if (MAX_GREEDY == 0) begin
        cnt_d = '0;
      end else if (next_q != last_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Selection sees the post-accept history so back-to-back issues rotate.
    // Descending loops leave the closest/lowest candidate as the final write.
    for (int k = NUM_WARPS; k >= 1; k--) begin
      sum = {1'b0, last_d} + (WID_W + 1)'(k);
      if (sum >= NW_EXT) sum = sum - NW_EXT;
      sel = sum[WID_W-1:0];
      if (eligible[sel]) begin
        lrr_found = 1'b1;
        lrr_pick  = sel;
      end
    end

    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      sel = WID_W'(i);
      if (eligible[sel] && (sel != last_d)) begin
        other_found = 1'b1;
        gto_other   = sel;
      end
    end

    greedy_ok = (MAX_GREEDY == 0) || (cnt_d < CNT_MAX);
    last_elig = eligible[last_d];

    if (policy) begin
      pick = (last_elig && (greedy_ok || !other_found)) ? last_d : gto_other;
    end else begin
      pick = lrr_pick;
    end

    if (load) begin
      valid_d = lrr_found;
      if (lrr_found) next_d = pick;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      next_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      next_q  <= next_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign next_warp  = next_q;
  assign warp_valid = valid_q;

endmodule
